// File: rtl/lockin_phase_scanner.sv
// Phase-offset scanner for a LockIn instance: passes a manual offset through while idle,
// otherwise steps the offset across N points, integrates the filtered signal at each point
// and remembers the offset that produced the largest signed integral.
module lockin_phase_scanner #(
   parameter int unsigned SIG_W       = 32,
   parameter int unsigned MAXDWELL_LG = 12,
   parameter int unsigned ACC_W       = 44
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    start_in,
   input  logic                    abort_in,
   input  logic [23:0]             manual_poff_in,
   input  logic [23:0]             phase_start_in,
   input  logic [23:0]             phase_step_in,
   input  logic [7:0]              num_steps_in,
   input  logic [15:0]             settle_in,
   input  logic [3:0]              dwell_log2_in,
   input  logic signed [SIG_W-1:0] signal_in,
   output logic [23:0]             poff_out,
   output logic                    busy_out,
   output logic                    done_out,
   output logic [7:0]              step_idx_out,
   output logic [23:0]             best_poff_out,
   output logic signed [ACC_W-1:0] best_acc_out
);

   // Sample counter wide enough to hold 2^MAXDWELL_LG - 1
   localparam int unsigned NS_W = MAXDWELL_LG + 1;

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StIntegrate,
      StCompare,
      StDone
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [23:0]              r_poff;
   logic [7:0]               r_step_idx;
   logic [15:0]              r_cnt;
   logic [NS_W-1:0]          r_ns;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [ACC_W-1:0]  r_best_acc;
   logic [23:0]              r_best_poff;
   logic [23:0]              r_cfg_step;
   logic [7:0]               r_cfg_last;
   logic [15:0]              r_cfg_settle;
   logic [3:0]               r_cfg_k;

   logic                     w_start;
   logic [3:0]               w_k_sat;
   logic [NS_W-1:0]          w_ns_init;
   logic signed [ACC_W-1:0]  w_sig_ext;
   logic signed [ACC_W-1:0]  w_acc_sum;
   logic                     w_better;
   logic                     w_last;

   // Datapath helpers: saturated dwell exponent, sample count, signed accumulate and compare
   always_comb begin
      w_start   = start_in && !abort_in;
      w_k_sat   = (dwell_log2_in > 4'(MAXDWELL_LG)) ? 4'(MAXDWELL_LG) : dwell_log2_in;
      w_ns_init = (NS_W'(1) << r_cfg_k) - NS_W'(1);
      w_sig_ext = {{(ACC_W - SIG_W){signal_in[SIG_W-1]}}, signal_in};
      w_acc_sum = r_acc + w_sig_ext;
      // First point always wins; later points must be strictly larger so ties keep the earlier
      w_better  = (r_step_idx == 8'd0) || (r_acc > r_best_acc);
      w_last    = (r_step_idx == r_cfg_last);
   end

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and status outputs; abort wins over everything while scanning
   always_comb begin
      w_state_nxt = r_state;
      busy_out    = 1'b0;
      done_out    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_start) w_state_nxt = StSettle;
         end
         StSettle: begin
            busy_out = 1'b1;
            if (abort_in)            w_state_nxt = StIdle;
            else if (r_cnt == 16'd0) w_state_nxt = StIntegrate;
         end
         StIntegrate: begin
            busy_out = 1'b1;
            if (abort_in)               w_state_nxt = StIdle;
            else if (r_ns == '0)        w_state_nxt = StCompare;
         end
         StCompare: begin
            busy_out = 1'b1;
            if (abort_in)    w_state_nxt = StIdle;
            else if (w_last) w_state_nxt = StDone;
            else             w_state_nxt = StSettle;
         end
         StDone: begin
            done_out    = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Scan datapath: offset sequencing, settle/dwell counters, accumulator and best tracking
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_poff       <= '0;
         r_step_idx   <= '0;
         r_cnt        <= '0;
         r_ns         <= '0;
         r_acc        <= '0;
         r_best_acc   <= '0;
         r_best_poff  <= '0;
         r_cfg_step   <= '0;
         r_cfg_last   <= '0;
         r_cfg_settle <= '0;
         r_cfg_k      <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_poff <= manual_poff_in;
               if (w_start) begin
                  r_poff       <= phase_start_in;
                  r_step_idx   <= 8'd0;
                  r_cnt        <= settle_in;
                  r_cfg_step   <= phase_step_in;
                  r_cfg_last   <= (num_steps_in == 8'd0) ? 8'd0 : num_steps_in - 8'd1;
                  r_cfg_settle <= settle_in;
                  r_cfg_k      <= w_k_sat;
               end
            end
            StSettle: begin
               if (abort_in) begin
                  r_poff <= manual_poff_in;
               end else if (r_cnt == 16'd0) begin
                  r_acc <= '0;
                  r_ns  <= w_ns_init;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            StIntegrate: begin
               if (abort_in) begin
                  r_poff <= manual_poff_in;
               end else begin
                  r_acc <= w_acc_sum;
                  if (r_ns != '0) r_ns <= r_ns - NS_W'(1);
               end
            end
            StCompare: begin
               if (abort_in) begin
                  r_poff <= manual_poff_in;
               end else begin
                  if (w_better) begin
                     r_best_acc  <= r_acc;
                     r_best_poff <= r_poff;
                  end
                  if (!w_last) begin
                     r_step_idx <= r_step_idx + 8'd1;
                     r_poff     <= r_poff + r_cfg_step;
                     r_cnt      <= r_cfg_settle;
                  end
               end
            end
            StDone: begin
               r_poff <= manual_poff_in;
            end
            default: begin
               r_poff <= manual_poff_in;
            end
         endcase
      end
   end

   assign poff_out      = r_poff;
   assign step_idx_out  = r_step_idx;
   assign best_poff_out = r_best_poff;
   assign best_acc_out  = r_best_acc;

endmodule

// File: tb/tb_lockin_phase_scanner.sv
// Scoreboarded random bench for lockin_phase_scanner: each completed scan's best point and
// completion time are predicted from the per-cycle signal table and checked on done_out.
module tb_lockin_phase_scanner;

   logic               clk_in = 1'b0;
   logic               rst_n_in;
   logic               start_in;
   logic               abort_in;
   logic [23:0]        manual_poff_in;
   logic [23:0]        phase_start_in;
   logic [23:0]        phase_step_in;
   logic [7:0]         num_steps_in;
   logic [15:0]        settle_in;
   logic [3:0]         dwell_log2_in;
   logic signed [31:0] signal_in;
   logic [23:0]        poff_out;
   logic               busy_out;
   logic               done_out;
   logic [7:0]         step_idx_out;
   logic [23:0]        best_poff_out;
   logic signed [43:0] best_acc_out;

   lockin_phase_scanner dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .start_in       (start_in),
      .abort_in       (abort_in),
      .manual_poff_in (manual_poff_in),
      .phase_start_in (phase_start_in),
      .phase_step_in  (phase_step_in),
      .num_steps_in   (num_steps_in),
      .settle_in      (settle_in),
      .dwell_log2_in  (dwell_log2_in),
      .signal_in      (signal_in),
      .poff_out       (poff_out),
      .busy_out       (busy_out),
      .done_out       (done_out),
      .step_idx_out   (step_idx_out),
      .best_poff_out  (best_poff_out),
      .best_acc_out   (best_acc_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [23:0] poff;
      longint      acc;
      logic [7:0]  idx;
      int          cyc;
   } exp_t;

   exp_t               q[$];
   int                 checks = 0;
   int                 errors = 0;
   int                 cyc = 0;
   logic signed [31:0] sig [0:8191];
   logic signed [31:0] pv [0:7];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk_in) cyc <= cyc + 1;

   // Monitor: every done pulse must match the oldest outstanding prediction
   always @(negedge clk_in) begin
      if (rst_n_in && done_out) begin
         chk("done_expected", longint'(q.size()), 1);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("best_poff", longint'(best_poff_out), longint'(e.poff));
            chk("best_acc", longint'(best_acc_out), e.acc);
            chk("final_step_idx", longint'(step_idx_out), longint'(e.idx));
            chk("done_cycle", longint'(cyc), longint'(e.cyc));
         end
      end
   end

   // sigmode: 0 random samples, 1 constant cval, 2 constant per point from pv[]
   // mode: 0 complete scan, 1 abort during first integrate cycle of point 1, 2 reset mid-settle
   task automatic run_scan(input logic [23:0] ps, input logic [23:0] st, input logic [7:0] n,
                           input logic [15:0] se, input logic [3:0] k, input int mode,
                           input int sigmode, input logic signed [31:0] cval);
      int          ne, ke, len, total, e0, ab;
      longint      acc, best;
      logic [23:0] bp, p, pe;
      exp_t        e;
      ne    = (n == 8'd0) ? 1 : int'(n);
      ke    = (k > 4'd12) ? 12 : int'(k);
      len   = int'(se) + 2 + (1 << ke);
      total = ne * len + 1;
      for (int c = 0; c <= total + 1; c++) begin
         if (sigmode == 0)                    sig[c] = $urandom;
         else if (sigmode == 1)               sig[c] = cval;
         else if (c >= 1 && c <= ne * len)    sig[c] = pv[(c - 1) / len];
         else                                 sig[c] = 32'sd0;
      end
      // Reference: sum each point's integration window, keep the first strict maximum
      best = 0;
      bp   = ps;
      p    = ps;
      for (int pi = 0; pi < ne; pi++) begin
         acc = 0;
         for (int j = 0; j < (1 << ke); j++) acc += sig[pi * len + int'(se) + 2 + j];
         if (pi == 0 || acc > best) begin
            best = acc;
            bp   = p;
         end
         p = p + st;
      end
      phase_start_in = ps;
      phase_step_in  = st;
      num_steps_in   = n;
      settle_in      = se;
      dwell_log2_in  = k;
      start_in       = 1'b1;
      @(posedge clk_in);
      #1;
      e0 = cyc;
      if (mode == 0) begin
         e.poff = bp;
         e.acc  = best;
         e.idx  = 8'(ne - 1);
         e.cyc  = e0 + total - 1;
         q.push_back(e);
      end
      start_in       = 1'b0;
      phase_start_in = $urandom;
      phase_step_in  = $urandom;
      num_steps_in   = $urandom;
      settle_in      = $urandom;
      dwell_log2_in  = $urandom;
      manual_poff_in = $urandom;
      ab = len + int'(se) + 2;
      for (int c = 1; c <= total + 1; c++) begin
         if (c <= ne * len && (c - 1) % len == 0) begin
            pe = ps + st * 24'((c - 1) / len);
            chk("point_poff", longint'(poff_out), longint'(pe));
            chk("point_idx", longint'(step_idx_out), longint'((c - 1) / len));
         end
         signal_in = sig[c];
         start_in  = (c == 3);
         abort_in  = (mode == 1 && c == ab);
         if (mode == 2 && c == 2) begin
            start_in = 1'b0;
            #2 rst_n_in = 1'b0;
            #1;
            chk("async_rst_poff", longint'(poff_out), 0);
            chk("async_rst_busy", longint'(busy_out), 0);
            chk("async_rst_best_acc", longint'(best_acc_out), 0);
            chk("async_rst_best_poff", longint'(best_poff_out), 0);
            rst_n_in = 1'b1;
            @(posedge clk_in);
            #1;
            return;
         end
         @(posedge clk_in);
         #1;
         if (mode == 1 && c == ab) begin
            abort_in = 1'b0;
            chk("abort_busy", longint'(busy_out), 0);
            @(posedge clk_in);
            #1;
            chk("abort_manual_poff", longint'(poff_out), longint'(manual_poff_in));
            return;
         end
      end
      start_in = 1'b0;
      chk("scan_retired", longint'(q.size()), 0);
   endtask

   initial begin
      rst_n_in       = 1'b1;
      start_in       = 1'b0;
      abort_in       = 1'b0;
      manual_poff_in = 24'h0;
      phase_start_in = 24'h0;
      phase_step_in  = 24'h0;
      num_steps_in   = 8'd0;
      settle_in      = 16'd0;
      dwell_log2_in  = 4'd0;
      signal_in      = 32'sd0;
      #1 rst_n_in = 1'b0;
      #2;
      chk("reset_poff", longint'(poff_out), 0);
      chk("reset_busy", longint'(busy_out), 0);
      chk("reset_done", longint'(done_out), 0);
      chk("reset_best_acc", longint'(best_acc_out), 0);
      @(negedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // Idle pass-through with one cycle of latency
      manual_poff_in = 24'h012345;
      @(posedge clk_in);
      #1;
      chk("idle_poff", longint'(poff_out), 24'h012345);
      chk("idle_busy", longint'(busy_out), 0);

      // Four points, tie between points 1 and 3 keeps point 1
      pv[0] = 32'sd100;
      pv[1] = 32'sd300;
      pv[2] = -32'sd50;
      pv[3] = 32'sd300;
      run_scan(24'h000000, 24'h400000, 8'd4, 16'd5, 4'd2, 0, 2, 32'sd0);
      chk("t2_best_poff", longint'(best_poff_out), 24'h400000);
      chk("t2_best_acc", longint'(best_acc_out), 1200);

      // Offset wraps from the most positive to the most negative value
      run_scan(24'h7FFFFF, 24'h000001, 8'd2, 16'd3, 4'd1, 0, 0, 32'sd0);
      pv[0] = -32'sd7;
      pv[1] = 32'sd5;
      run_scan(24'h7FFFFF, 24'h000001, 8'd2, 16'd1, 4'd1, 0, 2, 32'sd0);
      chk("t3_wrap_best_poff", longint'(best_poff_out), 24'h800000);

      // Abort mid-integration of the second point, then start+abort together while idle
      run_scan($urandom, $urandom, 8'd3, 16'd2, 4'd2, 1, 0, 32'sd0);
      start_in = 1'b1;
      abort_in = 1'b1;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      abort_in = 1'b0;
      chk("start_abort_idle", longint'(busy_out), 0);
      @(posedge clk_in);
      #1;

      for (int i = 0; i < 8; i++) begin
         run_scan($urandom, $urandom, 8'($urandom_range(0, 5)), 16'($urandom_range(0, 6)),
                  4'($urandom_range(0, 4)), 0, 0, 32'sd0);
         repeat ($urandom_range(0, 3)) @(posedge clk_in);
         #1;
      end

      // Single point, minimal settle, dwell saturated to 4096 samples of the most negative input
      run_scan(24'h123456, 24'h000010, 8'd0, 16'd0, 4'd15, 0, 1, 32'h80000000);
      chk("t5_best_acc", longint'(best_acc_out), -64'sd8796093022208);

      // Reset asserted mid-settle clears everything without a clock edge
      run_scan($urandom, $urandom, 8'd3, 16'd4, 4'd1, 2, 0, 32'sd0);
      repeat (3) @(posedge clk_in);
      #1;
      chk("final_pending", longint'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
